// File: rtl/hex_display_pkg.sv
// ----------------------------------------------------------------------------
// hex_display_pkg
// Shared definitions for the seven-segment display controller:
//   - register address map and CTRL bit positions
//   - active-high segment patterns (bit0..6 = a..g) for 0-F, dash and off
//   - decimal-conversion FSM state type
//   - bcd_add3: the add-3 correction step of the double-dabble converter
// ----------------------------------------------------------------------------
package hex_display_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 2;
    localparam int unsigned BCD_DIGITS = 10;
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned MAX_DIGITS = 8;

    // Register map
    localparam logic [ADDR_W-1:0] ADDR_VALUE = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_CTRL  = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_BLANK = 2'd2;

    // CTRL bit positions
    localparam int unsigned CTRL_DEC       = 0;
    localparam int unsigned CTRL_LZS       = 1;
    localparam int unsigned CTRL_DP_LSB    = 8;
    localparam int unsigned CTRL_BLINK_LSB = 16;

    // Active-high segment patterns, gfedcba
    localparam logic [6:0] SEG_PATTERNS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_SHIFT,
        CONV_DONE
    } conv_state_e;

    // Every BCD nibble >= 5 gets +3 so the following left shift carries
    // correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// ----------------------------------------------------------------------------
// hex_display_ctrl_if
// Register-write bus of the display controller.
//   iWR    : write strobe, one write per cycle
//   iADDR  : register select (VALUE / CTRL / BLANK / reserved)
//   iDATA  : write data
//   oBUSY  : decimal conversion in progress
// master = bus side (processor/peripheral bus), slave = display controller.
// ----------------------------------------------------------------------------
interface hex_display_ctrl_if;
    import hex_display_pkg::*;

    logic              iWR;
    logic [ADDR_W-1:0] iADDR;
    logic [DATA_W-1:0] iDATA;
    logic              oBUSY;

    modport master (
        output iWR,
        output iADDR,
        output iDATA,
        input  oBUSY
    );

    modport slave (
        input  iWR,
        input  iADDR,
        input  iDATA,
        output oBUSY
    );

endinterface

// File: rtl/hex_seg_decode.sv
// ----------------------------------------------------------------------------
// hex_seg_decode
// 4-bit value to seven-segment pattern, active-high (bit0..6 = a..g).
//   value : nibble to display
//   seg   : segment pattern, 1 = lit
// Output polarity is applied by the instantiating module.
// ----------------------------------------------------------------------------
module hex_seg_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_PATTERNS[value];
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// ----------------------------------------------------------------------------
// hex_display_ctrl
// Seven-segment display controller for up to eight digits.
//   iCLOCK   : system clock
//   iRESET_N : asynchronous active-low reset
//   bus      : register-write bus (iWR/iADDR/iDATA in, oBUSY out)
//   oHEX     : digit d at [8d+7:8d]; bit0..6 = segments a..g, bit7 = DP
// Registers: VALUE (number), CTRL (DEC, LZS, DP mask, blink mask),
// BLANK (per-digit force dark). Hex mode shows VALUE nibbles directly;
// decimal mode shows the latched result of a double-dabble conversion.
// ----------------------------------------------------------------------------
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned BLINK_HALF = 25_000_000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                    iCLOCK,
    input  logic                    iRESET_N,
    hex_display_ctrl_if.slave       bus,
    output logic [8*NUM_DIGITS-1:0] oHEX
);

    localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
    localparam logic [4:0] ITER_LAST = 5'd31;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]     value_q;
    logic                  ctrl_dec_q;
    logic                  ctrl_lzs_q;
    logic [MAX_DIGITS-1:0] dp_mask_q;
    logic [MAX_DIGITS-1:0] blink_mask_q;
    logic [MAX_DIGITS-1:0] blank_q;

    logic wr_value;
    logic wr_ctrl;
    logic wr_blank;

    always_comb begin
        wr_value = bus.iWR && (bus.iADDR == ADDR_VALUE);
        wr_ctrl  = bus.iWR && (bus.iADDR == ADDR_CTRL);
        wr_blank = bus.iWR && (bus.iADDR == ADDR_BLANK);
    end

    always_ff @(posedge iCLOCK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            value_q      <= '0;
            ctrl_dec_q   <= 1'b0;
            ctrl_lzs_q   <= 1'b0;
            dp_mask_q    <= '0;
            blink_mask_q <= '0;
            blank_q      <= '0;
        end else begin
            if (wr_value) begin
                value_q <= bus.iDATA;
            end
            if (wr_ctrl) begin
                ctrl_dec_q   <= bus.iDATA[CTRL_DEC];
                ctrl_lzs_q   <= bus.iDATA[CTRL_LZS];
                dp_mask_q    <= bus.iDATA[CTRL_DP_LSB +: MAX_DIGITS];
                blink_mask_q <= bus.iDATA[CTRL_BLINK_LSB +: MAX_DIGITS];
            end
            if (wr_blank) begin
                blank_q <= bus.iDATA[MAX_DIGITS-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Decimal conversion (double dabble)
    // ------------------------------------------------------------------
    conv_state_e       state_q, state_d;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  work_q, work_d;
    logic [4:0]        iter_q, iter_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;

    logic              conv_start;
    logic              conv_abort;
    logic [DATA_W-1:0] start_value;
    logic [BCD_W-1:0]  work_adj;

    always_comb begin
        // A VALUE write converts the incoming data, a CTRL 0->1 write
        // converts the stored VALUE.
        conv_start  = (wr_value && ctrl_dec_q) ||
                      (wr_ctrl && bus.iDATA[CTRL_DEC] && !ctrl_dec_q);
        conv_abort  = wr_ctrl && !bus.iDATA[CTRL_DEC];
        start_value = wr_value ? bus.iDATA : value_q;
        work_adj    = bcd_add3(work_q);
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        work_d  = work_q;
        iter_d  = iter_q;
        bcd_d   = bcd_q;

        if (conv_abort) begin
            state_d = CONV_IDLE;
        end else if (conv_start) begin
            // Restarting mid-conversion simply reloads; latest value wins.
            state_d = CONV_SHIFT;
            bin_d   = start_value;
            work_d  = '0;
            iter_d  = '0;
        end else begin
            case (state_q)
                CONV_SHIFT: begin
                    work_d = {work_adj[BCD_W-2:0], bin_q[DATA_W-1]};
                    bin_d  = {bin_q[DATA_W-2:0], 1'b0};
                    iter_d = iter_q + 5'd1;
                    if (iter_q == ITER_LAST) begin
                        state_d = CONV_DONE;
                    end
                end
                CONV_DONE: begin
                    bcd_d   = work_q;
                    state_d = CONV_IDLE;
                end
                default: begin
                    state_d = CONV_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge iCLOCK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            state_q <= CONV_IDLE;
            bin_q   <= '0;
            work_q  <= '0;
            iter_q  <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            work_q  <= work_d;
            iter_q  <= iter_d;
            bcd_q   <= bcd_d;
        end
    end

    assign bus.oBUSY = (state_q != CONV_IDLE);

    // ------------------------------------------------------------------
    // Blink timebase
    // ------------------------------------------------------------------
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_phase_q;

    always_ff @(posedge iCLOCK or negedge iRESET_N) begin
        if (!iRESET_N) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q   <= blink_cnt_q + BLINK_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Digit selection, suppression and output composition
    // ------------------------------------------------------------------
    logic [3:0]            nib     [NUM_DIGITS];
    logic [6:0]            seg_raw [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] nz_vec;
    logic [NUM_DIGITS-1:0] lzs_dark;
    logic                  bcd_ovf;
    logic                  ovf_active;

    always_comb begin
        bcd_ovf = 1'b0;
        for (int unsigned i = NUM_DIGITS; i < BCD_DIGITS; i++) begin
            bcd_ovf = bcd_ovf | (bcd_q[4*i +: 4] != 4'd0);
        end
        ovf_active = ctrl_dec_q && bcd_ovf;

        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            nib[d]    = ctrl_dec_q ? bcd_q[4*d +: 4] : value_q[4*d +: 4];
            nz_vec[d] = (nib[d] != 4'd0);
        end

        // A digit is leading when no displayed digit at or above it is
        // nonzero; digit 0 is never suppressed.
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            lzs_dark[d] = ctrl_lzs_q && !ovf_active && (d != 0) &&
                          !(|(nz_vec >> d));
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        hex_seg_decode u_seg_decode (
            .value (nib[g]),
            .seg   (seg_raw[g])
        );
    end

    always_comb begin
        logic       dark;
        logic       dp;
        logic [6:0] seg;
        logic [7:0] lit;

        oHEX = '0;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            dark = blank_q[d] || (blink_phase_q && blink_mask_q[d]);
            dp   = 1'b0;
            seg  = SEG_OFF;
            if (!dark) begin
                dp = dp_mask_q[d];
                if (lzs_dark[d]) begin
                    seg = SEG_OFF;
                end else if (ovf_active) begin
                    seg = SEG_DASH;
                end else begin
                    seg = seg_raw[d];
                end
            end
            lit = {dp, seg};
            oHEX[8*d +: 8] = ACTIVE_LOW ? ~lit : lit;
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;

    localparam int unsigned ND = 8;
    localparam int unsigned BH = 4;

    localparam logic [6:0] SEG_T [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [8*ND-1:0] hex;

    hex_display_ctrl_if bus ();

    hex_display_ctrl #(
        .NUM_DIGITS (ND),
        .BLINK_HALF (BH),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .iCLOCK   (clk),
        .iRESET_N (rst_n),
        .bus      (bus),
        .oHEX     (hex)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; blink phase is derived from this.
    int ncyc = 0;
    always @(posedge clk) begin
        if (!rst_n) ncyc <= 0;
        else        ncyc <= ncyc + 1;
    end

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sbq [$];

    int errors = 0;
    int checks = 0;

    logic [31:0] sh_value = '0;
    logic [31:0] sh_ctrl  = '0;
    logic [7:0]  sh_blank = '0;
    logic [31:0] last_dec = '0;

    // Reference display: decimal digits by repeated division.
    function automatic logic [63:0] model(input logic [31:0] v, input logic dec,
                                          input logic lzs, input logic [7:0] dpm,
                                          input logic [7:0] blm, input logic phase,
                                          input logic [7:0] blank);
        logic [3:0]      dig [8];
        logic            ovf;
        longint unsigned x;
        int              hi;
        logic [63:0]     r;
        logic [6:0]      s;
        ovf = 1'b0;
        x   = v;
        hi  = 0;
        r   = '0;
        for (int i = 0; i < 8; i++) begin
            if (dec) begin
                dig[i] = 4'(x % 10);
                x      = x / 10;
            end else begin
                dig[i] = v[4*i +: 4];
            end
        end
        if (dec) ovf = (x != 0);
        for (int i = 0; i < 8; i++) if (dig[i] != 4'd0) hi = i;
        for (int i = 0; i < 8; i++) begin
            if (blank[i] || (phase && blm[i])) begin
                r[8*i +: 8] = 8'hFF;
            end else begin
                if (lzs && !ovf && i > hi) s = 7'h00;
                else if (ovf)              s = 7'h40;
                else                       s = SEG_T[dig[i]];
                r[8*i +: 8] = ~{dpm[i], s};
            end
        end
        return r;
    endfunction

    task automatic push_exp(input string tag, input logic [31:0] dec_val);
        exp_t  e;
        logic  ph;
        ph    = ((ncyc / BH) % 2) == 1;
        e.tag = tag;
        e.val = model(sh_ctrl[0] ? dec_val : sh_value, sh_ctrl[0], sh_ctrl[1],
                      sh_ctrl[15:8], sh_ctrl[23:16], ph, sh_blank);
        sbq.push_back(e);
    endtask

    task automatic check_hex();
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: oHEX=%h expected <entry>", hex);
        end else begin
            e = sbq.pop_front();
            assert (hex === e.val) else begin
                errors++;
                $error("FAIL %s: oHEX=%h expected %h", e.tag, hex, e.val);
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.iWR   = 1'b1;
        bus.iADDR = a;
        bus.iDATA = d;
        @(negedge clk);
        bus.iWR   = 1'b0;
        case (a)
            2'd0:    sh_value = d;
            2'd1:    sh_ctrl  = d;
            2'd2:    sh_blank = d[7:0];
            default: ;
        endcase
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (bus.oBUSY === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Decimal write: hold check right away, then latency and final digits.
    task automatic dec_value(input string tag, input logic [31:0] v);
        int n;
        do_write(2'd0, v);
        push_exp({tag, "_hold"}, last_dec);
        check_hex();
        push_exp(tag, v);
        wait_busy(n);
        check_val({tag, "_busy_cycles"}, 64'(n), 64'd33);
        check_hex();
        last_dec = v;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.iWR   = 1'b0;
        bus.iADDR = '0;
        bus.iDATA = '0;
        repeat (3) @(negedge clk);

        // Reset state
        sbq.push_back('{"reset_digits", 64'hC0C0_C0C0_C0C0_C0C0});
        check_hex();
        check_val("reset_busy", 64'(bus.oBUSY), 64'd0);
        rst_n = 1'b1;

        // Hex mode
        do_write(2'd0, 32'h1234_ABCD);
        push_exp("hex_1234abcd", '0);
        check_hex();
        check_val("hex_digit0_d", 64'(hex[7:0]), 64'hA1);
        do_write(2'd0, 32'h00F0_0E09);
        push_exp("hex_00f00e09", '0);
        check_hex();

        // CTRL DEC 0->1 converts stored VALUE; prior result (0) held meanwhile
        do_write(2'd1, 32'h1);
        push_exp("ctrl_start_hold", last_dec);
        check_hex();
        check_val("ctrl_start_busy", 64'(bus.oBUSY), 64'd1);
        push_exp("ctrl_start_result", 32'h00F0_0E09);
        wait_busy(n);
        check_val("ctrl_start_busy_cycles", 64'(n), 64'd33);
        check_hex();
        last_dec = 32'h00F0_0E09;

        dec_value("dec_12345678", 32'd12345678);
        check_val("dec_12345678_const", hex, 64'hF9A4_B099_9282_F880);
        dec_value("dec_overflow", 32'd100000000);
        check_val("dec_overflow_const", hex, 64'hBFBF_BFBF_BFBF_BFBF);

        // LZS on: not applied while overflow is shown, no new conversion
        do_write(2'd1, 32'h3);
        check_val("lzs_ctrl_no_start", 64'(bus.oBUSY), 64'd0);
        push_exp("lzs_overflow", last_dec);
        check_hex();
        dec_value("lzs_42", 32'd42);
        check_val("lzs_42_const", hex, 64'hFFFF_FFFF_FFFF_99A4);
        dec_value("lzs_0", 32'd0);
        check_val("lzs_0_const", hex, 64'hFFFF_FFFF_FFFF_FFC0);

        // Restart: second VALUE write ten cycles into a conversion
        do_write(2'd0, 32'd99);
        repeat (8) @(negedge clk);
        check_val("restart_busy_mid", 64'(bus.oBUSY), 64'd1);
        dec_value("restart_7654321", 32'd7654321);

        // Abort by clearing DEC: hex shown immediately, no late result
        do_write(2'd0, 32'd555);
        repeat (5) @(negedge clk);
        do_write(2'd1, 32'h0);
        check_val("abort_busy", 64'(bus.oBUSY), 64'd0);
        push_exp("abort_hex", '0);
        check_hex();
        repeat (40) @(negedge clk);
        push_exp("abort_hex_later", '0);
        check_hex();

        // Reset during a conversion
        do_write(2'd1, 32'h1);
        push_exp("pre_reset_hold", last_dec);
        check_hex();
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("midreset_busy", 64'(bus.oBUSY), 64'd0);
        check_val("midreset_digits", hex, 64'hC0C0_C0C0_C0C0_C0C0);
        sh_value = '0; sh_ctrl = '0; sh_blank = '0; last_dec = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_val("postreset_busy", 64'(bus.oBUSY), 64'd0);
        push_exp("postreset_digits", '0);
        check_hex();

        // Blink mask 0x01, DP mask 0x02, BLANK 0x80
        do_write(2'd1, 32'h0001_0200);
        do_write(2'd2, 32'h80);
        do_write(2'd0, 32'h8765_4321);
        check_val("blank_digit7", 64'(hex[63:56]), 64'hFF);
        check_val("dp_digit1", 64'(hex[15]), 64'd0);
        for (int k = 0; k < 12; k++) begin
            push_exp($sformatf("blink_%0d", k), '0);
            check_hex();
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
